// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues sequential word fetches under a credit limit, buffers
// in-order responses in a small FIFO and presents {pc, inst} to decode; redirects flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef logic [CntW-1:0] cnt_t;
  typedef logic [PtrW-1:0] ptr_t;

  localparam cnt_t            DepthCnt  = cnt_t'(FIFO_DEPTH);
  localparam logic [CntW:0]   DepthWide = (CntW + 1)'(FIFO_DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] resp_pc_q, resp_pc_d;
  cnt_t        inflight_q, inflight_d;
  cnt_t        drop_cnt_q, drop_cnt_d;
  cnt_t        count_q, count_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  ptr_t        rd_ptr_q, rd_ptr_d;

  logic [31:0] pc_mem   [FIFO_DEPTH];
  logic [31:0] inst_mem [FIFO_DEPTH];

  logic          req_fire;
  logic          push;
  logic          pop;
  logic [CntW:0] credit_used;
  logic [31:0]   redirect_base;
  logic          unused_pc_bits;

  assign redirect_base  = {redirect_pc[31:2], 2'b00};
  assign unused_pc_bits = ^redirect_pc[1:0];

  // Outstanding requests plus buffered words never exceed the FIFO size, so no overflow.
  assign credit_used    = {1'b0, inflight_q} + {1'b0, count_q};
  assign imem_req_valid = !rst && !redirect_valid && (credit_used < DepthWide);
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = !rst && (count_q != '0);
  assign inst_o     = inst_mem[rd_ptr_q];
  assign inst_pc    = pc_mem[rd_ptr_q];

  assign push = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign pop  = inst_valid && inst_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (req_fire && !imem_resp_valid) begin
      inflight_d = inflight_q + cnt_t'(1);
    end else if (!req_fire && imem_resp_valid) begin
      inflight_d = inflight_q - cnt_t'(1);
    end

    if (redirect_valid) begin
      // Every request still outstanding after this edge belongs to the old path.
      fetch_pc_d = redirect_base;
      resp_pc_d  = redirect_base;
      drop_cnt_d = inflight_d;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (imem_resp_valid && (drop_cnt_q != '0)) begin
        drop_cnt_d = drop_cnt_q - cnt_t'(1);
      end
      if (push) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + ptr_t'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end
      if (push && !pop) begin
        count_d = count_q + cnt_t'(1);
      end else if (pop && !push) begin
        count_d = count_q - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_cnt_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      inst_mem[wr_ptr_q] <= imem_resp_data;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (count_q == DepthCnt)))
        else $error("fetch_unit: response into full buffer");
      assert (inflight_q <= DepthCnt && drop_cnt_q <= inflight_q)
        else $error("fetch_unit: credit counters out of range");
    end
  end
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch front end. Produces the 32-bit instruction word and PC consumed by the decode stage.
- Issues sequential word fetches to instruction memory over a valid/ready request channel. Accepts in-order responses and buffers them in a small FIFO.
- Presents instructions downstream with a valid/ready handshake.
- Handles redirects from branch/jump/trap resolution: flushes buffered words and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h8000_0000, PC of the first fetch after reset.
- FIFO_DEPTH, 4, instruction buffer entries; power of two, >= 2. Also the maximum number of outstanding requests.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
- imem_resp_valid  input  1  response data valid. Responses return in request order, latency >= 1 cycle, no backpressure.
- imem_resp_data  input  32  fetched instruction word.
- redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored (treated as 00).
- inst_valid  output  1  inst_o/inst_pc valid toward decode.
- inst_ready  input  1  decode consumes the word this cycle.
- inst_o  output  32  instruction word (decoder inst_i).
- inst_pc  output  32  PC of inst_o.

Behaviour:
- State:
  - fetch_pc: next address to request.
  - resp_pc: PC of next expected kept response.
  - inflight: 0..FIFO_DEPTH.
  - drop_cnt: 0..FIFO_DEPTH.
  - FIFO of {pc, inst} with read/write pointers and count.
- Reset (rst high at edge):
  - fetch_pc = resp_pc = RESET_PC.
  - inflight = drop_cnt = 0; FIFO empty.
  - While rst is high, imem_req_valid = 0 and inst_valid = 0. Reset mid-operation abandons all in-flight requests; responses arriving while rst is high are ignored.
- Request issue:
  - imem_req_valid = !rst && !redirect_valid && (inflight + count < FIFO_DEPTH), where count is the registered FIFO occupancy.
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc += 4 (wraps mod 2^32); inflight increments.
- Response handling (imem_resp_valid):
  - inflight decrements.
  - If drop_cnt > 0: discard the response, decrement drop_cnt.
  - Otherwise: write {resp_pc, imem_resp_data} into the FIFO and resp_pc += 4.
  - The credit rule guarantees the FIFO never overflows. A response arriving into a full FIFO is an assertion failure.
  - Simultaneous request handshake and response: inflight unchanged.
- Output:
  - inst_valid = (count != 0); inst_o/inst_pc = FIFO head, registered storage only, no combinational path from imem_resp.
  - Minimum latency from response to inst_valid: 1 cycle.
  - Pop on inst_valid && inst_ready. Simultaneous push and pop leaves count unchanged.
- Redirect (redirect_valid high; highest priority):
  - Next cycle: FIFO empty (any pop or push this cycle is discarded).
  - fetch_pc = resp_pc = {redirect_pc[31:2], 2'b00}.
  - drop_cnt = inflight - (imem_resp_valid ? 1 : 0) + drop_cnt adjustment, i.e. every request issued before the redirect edge and not yet returned is dropped.
  - The response in the redirect cycle is itself discarded.
  - No request is issued in the redirect cycle.
  - Back-to-back redirects: the last one wins; drop accounting still covers all in-flight requests.
- Invariants:
  - inflight <= FIFO_DEPTH; drop_cnt <= inflight.
  - inst_pc of consecutive kept entries differ by 4 unless separated by a redirect.

Test Plan:
- Reset then streaming, memory latency 1, inst_ready=1:
  - Expect requests 0x8000_0000, 0x8000_0004, ….
  - Expect inst_pc sequence 0x8000_0000, +4, … with matching inst_o.
  - Throughput 1 instruction/cycle after fill.
- Backpressure, inst_ready=0 for 10 cycles, FIFO_DEPTH=4:
  - inflight+count saturates at 4; imem_req_valid drops to 0; no overflow.
  - After ready rises, the 4 words drain in order with no loss.
- Redirect with 3 responses in flight, redirect_pc=0x8000_0103:
  - The 3 stale responses are discarded and the FIFO is flushed.
  - Next request address is 0x8000_0100; first inst_pc = 0x8000_0100.
- Redirect in the same cycle as imem_resp_valid and inst_ready:
  - The response is dropped and no stale word reaches decode.
  - No request is issued that cycle.
- rst asserted mid-stream with 2 requests outstanding:
  - inst_valid=0 next cycle; fetch restarts at RESET_PC.
  - Late responses arriving during rst are ignored.
- fetch_pc wrap: redirect to 0xFFFF_FFFC:
  - Requests 0xFFFF_FFFC then 0x0000_0000.
  - inst_pc follows the same wrap.
